// File: rtl/float_pkg.sv
// Shared definitions for the float datapath blocks: Gray-coded FSM states,
// status flag bit positions and field-width helpers.
package float_pkg;

  localparam int STATE_W = 4;

  // Bit positions inside the 3-bit status word {ovf, unf, inexact}.
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;

  // Binary-reflected Gray code of a state index.
  function automatic logic [STATE_W-1:0] gray(input logic [STATE_W-1:0] idx);
    return idx ^ (idx >> 1);
  endfunction

  // Packed word width for a {sign, exp, frac} float.
  function automatic int word_width(input int ew, input int fw);
    return 1 + ew + fw;
  endfunction

  // Exponent bias for an ew-bit exponent field.
  function automatic int exp_bias(input int ew);
    return 1 << (ew - 1);
  endfunction

  // Largest representable biased exponent (no inf/NaN encodings).
  function automatic int exp_max(input int ew);
    return (1 << ew) - 1;
  endfunction

  // Consecutive states differ in one bit along the common path.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = gray(4'd1),
    ST_LOAD    = gray(4'd2),
    ST_SPECIAL = gray(4'd3),
    ST_ALIGN   = gray(4'd4),
    ST_ADD     = gray(4'd5),
    ST_NORM_R  = gray(4'd6),
    ST_NORM_L  = gray(4'd7),
    ST_ROUND   = gray(4'd8),
    ST_PACK    = gray(4'd9)
  } state_e;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalised {hidden, frac} mantissa using its
// guard/round/sticky bits. Purely combinational.
module fp_round_rne
  import float_pkg::*;
#(
  parameter int FW = 10
) (
  input  logic [FW:0] mant_i,
  input  logic [2:0]  grs_i,
  output logic [FW:0] mant_o,
  output logic        carry_o,
  output logic        inexact_o
);

  logic          inc;
  logic [FW+1:0] sum;

  // Increment on more-than-half, or exactly half with an odd LSB.
  always_comb begin
    inc       = grs_i[2] & (grs_i[1] | grs_i[0] | mant_i[0]);
    sum       = {1'b0, mant_i} + {{(FW + 1){1'b0}}, inc};
    mant_o    = sum[FW:0];
    carry_o   = sum[FW+1];
    inexact_o = |grs_i;
  end

endmodule

// File: rtl/fp_addsub_rne.sv
// Iterative floating-point add/subtract: one shift per cycle for alignment
// and normalisation, RNE rounding, overflow saturation, underflow flush.
// Operations are started by toggling req; ack is high only when idle.
module fp_addsub_rne
  import float_pkg::*;
#(
  parameter  int EW    = 6,
  parameter  int FW    = 10,
  parameter  int MAXSH = FW + 3,
  localparam int W     = word_width(EW, FW)
) (
  input  logic               clk0,
  input  logic               rstn,
  input  logic               enable,
  input  logic               req,
  input  logic               op,
  input  logic [W-1:0]       rx_data_1,
  input  logic [W-1:0]       rx_data_2,
  output logic               ack,
  output logic [W-1:0]       tx_data,
  output logic [2:0]         flags,
  output logic [STATE_W-1:0] cst
);

  // Mantissa {carry, hidden, frac, G, R, S}; exponent with headroom for
  // the normalise and round carries.
  localparam int MW = FW + 5;
  localparam int XW = EW + 2;
  localparam logic signed [XW-1:0] EXP_ONE   = XW'(1);
  localparam logic signed [XW-1:0] EXP_TOP   = XW'(exp_max(EW));
  localparam logic signed [XW-1:0] EXP_MAXSH = XW'(MAXSH);

  state_e                state_q, state_d;
  logic                  req_q, req_d;
  logic                  sign_a_q, sign_a_d;
  logic                  sign_b_q, sign_b_d;
  logic signed [XW-1:0]  exp_a_q, exp_a_d;
  logic signed [XW-1:0]  exp_b_q, exp_b_d;
  logic [MW-1:0]         man_a_q, man_a_d;
  logic [MW-1:0]         man_b_q, man_b_d;
  logic                  zero_q, zero_d;
  logic                  inexact_q, inexact_d;
  logic [W-1:0]          tx_q, tx_d;
  logic [2:0]            flags_q, flags_d;

  logic                  start;
  logic                  swap;
  logic signed [XW-1:0]  exp_diff;
  logic [MW-1:0]         add_res;
  logic [MW-1:0]         shl_res;
  logic [FW:0]           rnd_mant;
  logic                  rnd_carry;
  logic                  rnd_inexact;

  // The registered request copy only follows req while idle, so a toggle
  // made during a busy operation stays pending and starts the next one.
  assign start    = req ^ req_q;
  assign swap     = (exp_b_q > exp_a_q) ||
                    ((exp_b_q == exp_a_q) && (man_b_q > man_a_q));
  assign exp_diff = exp_a_q - exp_b_q;
  // a is never smaller than b after the swap, so the difference is >= 0.
  assign add_res  = (sign_a_q ^ sign_b_q) ? (man_a_q - man_b_q)
                                          : (man_a_q + man_b_q);
  assign shl_res  = man_a_q << 1;

  fp_round_rne #(.FW(FW)) u_round (
    .mant_i    (man_a_q[FW+3:3]),
    .grs_i     (man_a_q[2:0]),
    .mant_o    (rnd_mant),
    .carry_o   (rnd_carry),
    .inexact_o (rnd_inexact)
  );

  // Next-state and datapath update for every state; enable low clears all.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d   = state_q;
    req_d     = req_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    exp_a_d   = exp_a_q;
    exp_b_d   = exp_b_q;
    man_a_d   = man_a_q;
    man_b_d   = man_b_q;
    zero_d    = zero_q;
    inexact_d = inexact_q;
    tx_d      = tx_q;
    flags_d   = flags_q;

    case (state_q)
      ST_IDLE: begin
        req_d = req;
        if (start) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        sign_a_d  = rx_data_1[W-1];
        exp_a_d   = {2'b00, rx_data_1[W-2:FW]};
        man_a_d   = {2'b01, rx_data_1[FW-1:0], 3'b000};
        sign_b_d  = rx_data_2[W-1] ^ op;
        exp_b_d   = {2'b00, rx_data_2[W-2:FW]};
        man_b_d   = {2'b01, rx_data_2[FW-1:0], 3'b000};
        zero_d    = 1'b0;
        inexact_d = 1'b0;
        state_d   = ST_SPECIAL;
      end

      // Zero operands bypass the datapath. The magnitude swap happens here
      // so that every ALIGN cycle is a real shift.
      ST_SPECIAL: begin
        if (exp_a_q == '0 && exp_b_q == '0) begin
          zero_d   = 1'b1;
          sign_a_d = sign_a_q & sign_b_q;
          state_d  = ST_PACK;
        end else if (exp_a_q == '0) begin
          sign_a_d = sign_b_q;
          exp_a_d  = exp_b_q;
          man_a_d  = man_b_q;
          state_d  = ST_PACK;
        end else if (exp_b_q == '0) begin
          state_d  = ST_PACK;
        end else begin
          if (swap) begin
            sign_a_d = sign_b_q;
            exp_a_d  = exp_b_q;
            man_a_d  = man_b_q;
            sign_b_d = sign_a_q;
            exp_b_d  = exp_a_q;
            man_b_d  = man_a_q;
          end
          state_d = (exp_a_q == exp_b_q) ? ST_ADD : ST_ALIGN;
        end
      end

      // Shift b right one place per cycle, folding lost bits into sticky;
      // a distance beyond MAXSH leaves only sticky, done in one step.
      ST_ALIGN: begin
        if (exp_diff > EXP_MAXSH) begin
          man_b_d = {{(MW - 1){1'b0}}, |man_b_q};
          exp_b_d = exp_a_q;
          state_d = ST_ADD;
        end else begin
          man_b_d = {1'b0, man_b_q[MW-1:2], man_b_q[1] | man_b_q[0]};
          exp_b_d = exp_b_q + EXP_ONE;
          if (exp_diff == EXP_ONE) state_d = ST_ADD;
        end
      end

      ST_ADD: begin
        man_a_d = add_res;
        if (add_res == '0) begin
          zero_d   = 1'b1;
          sign_a_d = 1'b0;
          state_d  = ST_PACK;
        end else if (add_res[MW-1]) begin
          state_d = ST_NORM_R;
        end else if (!add_res[MW-2]) begin
          state_d = ST_NORM_L;
        end else begin
          state_d = ST_ROUND;
        end
      end

      ST_NORM_R: begin
        man_a_d = {1'b0, man_a_q[MW-1:2], man_a_q[1] | man_a_q[0]};
        exp_a_d = exp_a_q + EXP_ONE;
        state_d = ST_ROUND;
      end

      // Exponent hitting zero ends the op as an underflow flush.
      ST_NORM_L: begin
        man_a_d = shl_res;
        exp_a_d = exp_a_q - EXP_ONE;
        if (exp_a_q == EXP_ONE)   state_d = ST_PACK;
        else if (shl_res[MW-2])   state_d = ST_ROUND;
      end

      ST_ROUND: begin
        inexact_d = rnd_inexact;
        if (rnd_carry) begin
          man_a_d = {2'b01, {FW{1'b0}}, 3'b000};
          exp_a_d = exp_a_q + EXP_ONE;
        end else begin
          man_a_d = {1'b0, rnd_mant, 3'b000};
        end
        state_d = ST_PACK;
      end

      ST_PACK: begin
        flags_d = '0;
        if (zero_q) begin
          tx_d = {sign_a_q, {(W - 1){1'b0}}};
        end else if (exp_a_q > EXP_TOP) begin
          tx_d              = {sign_a_q, {EW{1'b1}}, {FW{1'b1}}};
          flags_d[FLAG_OVF] = 1'b1;
          flags_d[FLAG_INX] = 1'b1;
        end else if (exp_a_q < EXP_ONE) begin
          tx_d              = '0;
          flags_d[FLAG_UNF] = 1'b1;
          flags_d[FLAG_INX] = 1'b1;
        end else begin
          tx_d              = {sign_a_q, exp_a_q[EW-1:0], man_a_q[FW+2:3]};
          flags_d[FLAG_INX] = inexact_q;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Enable low aborts any op and returns everything to its reset value.
    if (!enable) begin
      state_d   = ST_IDLE;
      req_d     = 1'b0;
      sign_a_d  = 1'b0;
      sign_b_d  = 1'b0;
      exp_a_d   = '0;
      exp_b_d   = '0;
      man_a_d   = '0;
      man_b_d   = '0;
      zero_d    = 1'b0;
      inexact_d = 1'b0;
      tx_d      = '0;
      flags_d   = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk0 or negedge rstn) begin
    // NOTE: async reset lives only in the sensitivity list and first branch;
    // the same values are reached synchronously through enable above.
    if (!rstn) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      exp_a_q   <= '0;
      exp_b_q   <= '0;
      man_a_q   <= '0;
      man_b_q   <= '0;
      zero_q    <= 1'b0;
      inexact_q <= 1'b0;
      tx_q      <= '0;
      flags_q   <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q   <= state_d;
      req_q     <= req_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      exp_a_q   <= exp_a_d;
      exp_b_q   <= exp_b_d;
      man_a_q   <= man_a_d;
      man_b_q   <= man_b_d;
      zero_q    <= zero_d;
      inexact_q <= inexact_d;
      tx_q      <= tx_d;
      flags_q   <= flags_d;
    end
  end

  assign ack     = (state_q == ST_IDLE);
  assign cst     = state_q;
  assign tx_data = tx_q;
  assign flags   = flags_q;

endmodule

// File: tb/tb_fp_addsub_rne.sv
// Directed bench for fp_addsub_rne (EW=6, FW=10): arithmetic results and
// flags, busy-cycle counts, pending request toggles, enable abort, reset.
module tb_fp_addsub_rne;

  localparam int EW = 6;
  localparam int FW = 10;
  localparam int W  = 1 + EW + FW;
  localparam int WAIT_LIMIT = 200;

  logic         clk0 = 1'b0;
  logic         rstn = 1'b1;
  logic         enable = 1'b1;
  logic         req = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] rx_data_1 = '0;
  logic [W-1:0] rx_data_2 = '0;
  logic         ack;
  logic [W-1:0] tx_data;
  logic [2:0]   flags;
  logic [3:0]   cst;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  fp_addsub_rne #(.EW(EW), .FW(FW)) dut (
    .clk0      (clk0),
    .rstn      (rstn),
    .enable    (enable),
    .req       (req),
    .op        (op),
    .rx_data_1 (rx_data_1),
    .rx_data_2 (rx_data_2),
    .ack       (ack),
    .tx_data   (tx_data),
    .flags     (flags),
    .cst       (cst)
  );

  always #5 clk0 = ~clk0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Drive operands and toggle req at a falling edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic o);
    @(negedge clk0);
    rx_data_1 = a;
    rx_data_2 = b;
    op        = o;
    req       = ~req;
  endtask

  // Count falling edges with ack low until ack returns, bounded.
  task automatic wait_done(output int cycles);
    cycles = 0;
    @(negedge clk0);
    while (ack !== 1'b1 && cycles < WAIT_LIMIT) begin
      cycles++;
      @(negedge clk0);
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic o, input logic [W-1:0] exp_tx,
                        input logic [2:0] exp_fl, input int exp_cyc);
    int c;
    start_op(a, b, o);
    wait_done(c);
    check({tag, ".ack"}, ack, 1);
    check({tag, ".tx"}, tx_data, exp_tx);
    check({tag, ".flags"}, flags, exp_fl);
    check({tag, ".busy"}, c, exp_cyc);
  endtask

  initial begin
    // Asynchronous reset state.
    #1 rstn = 1'b0;
    #1;
    check("rst.ack", ack, 1);
    check("rst.cst", cst, 4'h1);
    check("rst.tx", tx_data, 0);
    check("rst.flags", flags, 0);
    @(negedge clk0);
    rstn = 1'b1;

    // 1.0 + 1.0 = 2.0 through the carry/NORM_R path.
    run_op("add_1_1", 17'h08000, 17'h08000, 1'b0, 17'h08400, 3'b000, 6);
    // Exact cancellation gives +0 with no flags.
    run_op("sub_1_1", 17'h08000, 17'h08000, 1'b1, 17'h00000, 3'b000, 4);
    // Half-ULP ties: even LSB stays, odd LSB rounds up.
    run_op("tie_even", 17'h08000, 17'h05400, 1'b0, 17'h08000, 3'b001, 16);
    run_op("tie_odd", 17'h08001, 17'h05400, 1'b0, 17'h08002, 3'b001, 16);
    // 1.0 - 2^-11 = 0.11111111111b, one NORM_L step.
    run_op("sub_norm_l", 17'h08000, 17'h05400, 1'b1, 17'h07FFF, 3'b000, 17);
    // Both -0 keep the sign; zero a passes b with its sign flipped by op.
    run_op("neg_zeros", 17'h10000, 17'h10000, 1'b0, 17'h10000, 3'b000, 3);
    run_op("zero_sub_b", 17'h00000, 17'h08000, 1'b1, 17'h18000, 3'b000, 3);

    // Pending toggle made while busy starts only after the unit returns idle.
    start_op(17'h00000, 17'h18C00, 1'b0);
    @(negedge clk0);
    @(negedge clk0);
    rx_data_1 = 17'h08000;
    rx_data_2 = 17'h08000;
    op        = 1'b0;
    req       = ~req;
    wait_done(cyc);
    check("pend.first_busy_left", cyc, 1);
    check("pend.first_tx", tx_data, 17'h18C00);
    check("pend.first_flags", flags, 3'b000);
    @(negedge clk0);
    check("pend.second_started", ack, 0);
    check("pend.second_cst", cst, 4'h3);
    wait_done(cyc);
    check("pend.second_busy", cyc, 5);
    check("pend.second_tx", tx_data, 17'h08400);

    // Enable dropped during ALIGN aborts the op and clears tx_data.
    start_op(17'h08000, 17'h05400, 1'b0);
    @(negedge clk0);
    @(negedge clk0);
    @(negedge clk0);
    check("en.in_align", cst, 4'h6);
    enable = 1'b0;
    req    = 1'b0;
    @(negedge clk0);
    check("en.cst", cst, 4'h1);
    check("en.ack", ack, 1);
    check("en.tx", tx_data, 0);
    check("en.flags", flags, 0);
    enable = 1'b1;

    // Exponent gap beyond the shift cap collapses b to sticky.
    run_op("sticky_cap", 17'h08000, 17'h00400, 1'b0, 17'h08000, 3'b001, 6);

    // Reset pulse mid-op clears outputs without waiting for a clock edge.
    start_op(17'h0FFFF, 17'h0FFFF, 1'b0);
    @(negedge clk0);
    @(negedge clk0);
    #2 rstn = 1'b0;
    #1;
    check("rstpulse.ack", ack, 1);
    check("rstpulse.cst", cst, 4'h1);
    check("rstpulse.tx", tx_data, 0);
    check("rstpulse.flags", flags, 0);
    @(negedge clk0);
    rstn = 1'b1;
    req  = 1'b0;

    // Largest value doubled saturates; near-minimum cancellation flushes.
    run_op("overflow", 17'h0FFFF, 17'h0FFFF, 1'b0, 17'h0FFFF, 3'b101, 6);
    run_op("underflow", 17'h00400, 17'h00401, 1'b1, 17'h00000, 3'b011, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog in case a wait loop misbehaves.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
